// File: rtl/enthdr_pkg.sv
// Shared definitions for the ENTHDR0 controller and target: default bus constants
// and the common sequence state encoding.
package enthdr_pkg;

    localparam logic [6:0] BROADCAST_ADDR_DEF = 7'h7E;
    localparam logic [7:0] ENTHDR_CMD_DEF     = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDRESS,
        ST_ACK,
        ST_CMD,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } enthdr_state_e;

endpackage

// File: rtl/enthdr_bit_shifter.sv
// MSB-first byte serialiser: load presents bit 7, each shift presents the next bit
// and counts down; the count wraps 0->7 at the byte boundary.
module enthdr_bit_shifter (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift,
    output logic       sda_next,
    output logic [2:0] bit_cnt
);

    logic [6:0] tail;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            tail    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            tail    <= load_data[6:0];
            bit_cnt <= 3'd7;
        end else if (shift) begin
            tail    <= {tail[5:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
        end
    end

    // Value the caller registers onto SDA in the same cycle as load/shift.
    assign sda_next = load ? load_data[7] : tail[6];

endmodule

// File: rtl/enthdr_ctrl.sv
// Controller side of the I3C ENTHDR0 entry: START, broadcast address, ACK, the
// ENTHDR0 CCC and the T bit, or a STOP when the address is NACKed.
module enthdr_ctrl
    import enthdr_pkg::*;
#(
    parameter logic [6:0] BROADCAST_ADDR = BROADCAST_ADDR_DEF,
    parameter logic [7:0] ENTHDR_CMD     = ENTHDR_CMD_DEF,
    parameter int         START_HOLD     = 4
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_engine_en,
    input  logic i_sda,
    input  logic i_scl_pos_edge,
    input  logic i_scl_neg_edge,
    output logic o_sda,
    output logic o_pp_od,
    output logic o_scl_run,
    output logic o_engine_done,
    output logic o_nack
);

    localparam logic [7:0] HOLD_LAST = 8'(START_HOLD - 1);
    localparam logic       PARITY_T  = ~^ENTHDR_CMD;

    enthdr_state_e state;
    logic [7:0]    hold_cnt;
    logic          ack_seen;
    logic          nack_flag;
    logic          rearm_wait;

    logic       pos_stb;
    logic       neg_stb;
    logic       sh_load;
    logic       sh_shift;
    logic [7:0] sh_load_data;
    logic       sh_sda_next;
    logic [2:0] bit_cnt;

    // A coincident pair of strobes is treated as a rising edge only.
    assign pos_stb = i_scl_pos_edge;
    assign neg_stb = i_scl_neg_edge & ~i_scl_pos_edge;

    assign sh_load = i_engine_en & neg_stb &
                     (((state == ST_START) & o_scl_run) |
                      ((state == ST_ACK) & ack_seen & ~nack_flag));
    assign sh_shift = i_engine_en & neg_stb &
                      ((state == ST_ADDRESS) | (state == ST_CMD));
    assign sh_load_data = (state == ST_ACK) ? ENTHDR_CMD : {BROADCAST_ADDR, 1'b0};

    enthdr_bit_shifter u_shifter (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (sh_shift),
        .sda_next  (sh_sda_next),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state         <= ST_IDLE;
            o_sda         <= 1'b1;
            o_pp_od       <= 1'b0;
            o_scl_run     <= 1'b0;
            o_engine_done <= 1'b0;
            o_nack        <= 1'b0;
            hold_cnt      <= '0;
            ack_seen      <= 1'b0;
            nack_flag     <= 1'b0;
            rearm_wait    <= 1'b0;
        end else begin
            o_engine_done <= 1'b0;
            o_nack        <= 1'b0;
            if (state != ST_IDLE && !i_engine_en) begin
                state     <= ST_IDLE;
                o_sda     <= 1'b1;
                o_pp_od   <= 1'b0;
                o_scl_run <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        o_sda     <= 1'b1;
                        o_pp_od   <= 1'b0;
                        o_scl_run <= 1'b0;
                        if (!i_engine_en) begin
                            rearm_wait <= 1'b0;
                        end else if (!rearm_wait) begin
                            state    <= ST_START;
                            o_sda    <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (!o_scl_run) begin
                            if (hold_cnt == HOLD_LAST) o_scl_run <= 1'b1;
                            else                       hold_cnt  <= hold_cnt + 8'd1;
                        end else if (neg_stb) begin
                            state <= ST_ADDRESS;
                            o_sda <= sh_sda_next;
                        end
                    end
                    ST_ADDRESS: begin
                        if (neg_stb) begin
                            if (bit_cnt == 3'd0) begin
                                state     <= ST_ACK;
                                o_sda     <= 1'b1;
                                ack_seen  <= 1'b0;
                                nack_flag <= 1'b0;
                            end else begin
                                o_sda <= sh_sda_next;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (pos_stb) begin
                            ack_seen  <= 1'b1;
                            nack_flag <= i_sda;
                        end else if (neg_stb && ack_seen) begin
                            if (nack_flag) begin
                                state     <= ST_STOP;
                                o_sda     <= 1'b0;
                                o_scl_run <= 1'b0;
                                hold_cnt  <= '0;
                            end else begin
                                state   <= ST_CMD;
                                o_pp_od <= 1'b1;
                                o_sda   <= sh_sda_next;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (neg_stb) begin
                            if (bit_cnt == 3'd0) begin
                                state <= ST_PARITY;
                                o_sda <= PARITY_T;
                            end else begin
                                o_sda <= sh_sda_next;
                            end
                        end
                    end
                    // SCL keeps running and push-pull stays on: the bus is now in HDR.
                    ST_PARITY: begin
                        if (neg_stb) begin
                            state         <= ST_DONE;
                            o_engine_done <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state         <= ST_DONE;
                            o_sda         <= 1'b1;
                            o_engine_done <= 1'b1;
                            o_nack        <= nack_flag;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    ST_DONE: begin
                        state      <= ST_IDLE;
                        rearm_wait <= 1'b1;
                        o_sda      <= 1'b1;
                        o_pp_od    <= 1'b0;
                        o_scl_run  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enthdr_ctrl.sv
// Directed bench for enthdr_ctrl with a divide-by-8 SCL generator and a target
// that optionally pulls SDA low during the address ACK bit.
module tb_enthdr_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic i_sda;
    logic pos_e;
    logic neg_e;
    logic o_sda;
    logic o_pp_od;
    logic o_scl_run;
    logic o_engine_done;
    logic o_nack;

    int checks   = 0;
    int failures = 0;

    logic scl     = 1'b1;
    int   div     = 0;
    int   npos    = 0;
    int   ndone   = 0;
    logic tgt_ack = 1'b1;
    logic bits [0:19];

    always #5 clk = ~clk;

    enthdr_ctrl dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst),
        .i_engine_en    (en),
        .i_sda          (i_sda),
        .i_scl_pos_edge (pos_e),
        .i_scl_neg_edge (neg_e),
        .o_sda          (o_sda),
        .o_pp_od        (o_pp_od),
        .o_scl_run      (o_scl_run),
        .o_engine_done  (o_engine_done),
        .o_nack         (o_nack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: choose strobes from the SCL model, record SDA at each rising SCL.
    task automatic cyc();
        logic p;
        logic n;
        p = 1'b0;
        n = 1'b0;
        if (!o_scl_run) begin
            scl = 1'b1;
            div = 0;
        end else if (div == 3) begin
            div = 0;
            if (scl) begin n = 1'b1; scl = 1'b0; end
            else     begin p = 1'b1; scl = 1'b1; end
        end else begin
            div++;
        end
        i_sda = 1'b1;
        if (p) begin
            if (tgt_ack && npos == 8) i_sda = 1'b0;
            if (npos < 20) bits[npos] = o_sda;
            npos++;
        end
        pos_e = p;
        neg_e = n;
        @(posedge clk);
        #1;
        if (o_engine_done) ndone++;
    endtask

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = bits[base+k];
        return b;
    endfunction

    task automatic run_to_done(input string tag);
        int i;
        i = 0;
        while (i < 600 && !o_engine_done) begin
            cyc();
            i++;
        end
        chk(tag, o_engine_done, 1'b1);
    endtask

    task automatic start_seq(input logic ack);
        en = 1'b0;
        cyc();
        tgt_ack = ack;
        npos    = 0;
        ndone   = 0;
        en      = 1'b1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        i_sda = 1'b1;
        pos_e = 1'b0;
        neg_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda", o_sda, 1'b1);
        chk("rst_pp_od", o_pp_od, 1'b0);
        chk("rst_scl_run", o_scl_run, 1'b0);
        chk("rst_done", o_engine_done, 1'b0);
        chk("rst_nack", o_nack, 1'b0);
        rst = 1'b0;
        cyc();

        // Both strobes together while waiting for the first falling SCL: no advance.
        en = 1'b1;
        for (int i = 0; i < 50 && !o_scl_run; i++) cyc();
        chk("start_scl_run", o_scl_run, 1'b1);
        pos_e = 1'b1;
        neg_e = 1'b1;
        @(posedge clk);
        #1;
        chk("both_strobes_sda", o_sda, 1'b0);
        en = 1'b0;
        cyc();
        chk("abort_start_sda", o_sda, 1'b1);
        chk("abort_start_scl", o_scl_run, 1'b0);

        // Target ACKs: full ENTHDR0 entry.
        start_seq(1'b1);
        run_to_done("ack_done");
        chk("ack_nack", o_nack, 1'b0);
        chk("ack_scl_run", o_scl_run, 1'b1);
        chk("ack_pp_od", o_pp_od, 1'b1);
        chk("ack_addr", byte_at(0), 8'hFC);
        chk("ack_bit", bits[8], 1'b1);
        chk("ack_cmd", byte_at(9), 8'h20);
        chk("ack_tbit", bits[17], 1'b0);
        chk("ack_nbits", npos, 18);
        for (int i = 0; i < 20; i++) cyc();
        chk("ack_single_done", ndone, 1);
        chk("ack_no_rerun", o_scl_run, 1'b0);

        // No target: NACK then STOP.
        start_seq(1'b0);
        run_to_done("nack_done");
        chk("nack_nack", o_nack, 1'b1);
        chk("nack_sda", o_sda, 1'b1);
        chk("nack_scl_run", o_scl_run, 1'b0);
        chk("nack_nbits", npos, 9);
        chk("nack_addr", byte_at(0), 8'hFC);
        cyc();
        chk("nack_pulse_len", o_engine_done, 1'b0);

        // Drop enable while CMD bit 4 is on the bus.
        start_seq(1'b1);
        for (int i = 0; i < 600 && npos < 13; i++) cyc();
        chk("abort_reach_bit4", npos, 13);
        chk("abort_pp_before", o_pp_od, 1'b1);
        en = 1'b0;
        cyc();
        chk("abort_sda", o_sda, 1'b1);
        chk("abort_scl_run", o_scl_run, 1'b0);
        chk("abort_pp_od", o_pp_od, 1'b0);
        chk("abort_done", o_engine_done, 1'b0);
        for (int i = 0; i < 10; i++) cyc();
        chk("abort_no_done", ndone, 0);

        // Asynchronous reset while address bit 3 is on the bus.
        start_seq(1'b1);
        for (int i = 0; i < 600 && npos < 5; i++) cyc();
        chk("rstmid_reach", npos, 5);
        chk("rstmid_scl_before", o_scl_run, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_sda", o_sda, 1'b1);
        chk("rstmid_scl", o_scl_run, 1'b0);
        chk("rstmid_pp_od", o_pp_od, 1'b0);
        chk("rstmid_done", o_engine_done, 1'b0);
        chk("rstmid_nack", o_nack, 1'b0);
        cyc();
        cyc();
        rst   = 1'b0;
        npos  = 0;
        ndone = 0;
        run_to_done("rerun_done");
        chk("rerun_nack", o_nack, 1'b0);
        chk("rerun_addr", byte_at(0), 8'hFC);
        chk("rerun_cmd", byte_at(9), 8'h20);
        chk("rerun_tbit", bits[17], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
